// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: default widths, reset/NOP
// encodings and the next-PC source selector.
package mips_pkg;

  localparam int ADDR_WIDTH_DEFAULT  = 32;
  localparam int INSTR_WIDTH_DEFAULT = 32;

  // PC loaded when reset is asserted.
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // sll $0,$0,0 -- the canonical MIPS no-op, used for pipeline bubbles.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam int PC_STEP = 4;

  // Source of the PC value for the next cycle.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_HOLD   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundle of control, instruction-memory and IF/ID signals around the fetch
// stage. The slave side is the fetch stage itself; the master side is the
// surrounding pipeline (hazard unit, EX/ID redirects, imem, decode).
interface if_fetch_stage_if
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT
);

  // Control from hazard unit / branch resolution / decode.
  logic                   stall;
  logic                   branch_taken;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic                   jump_taken;
  logic [ADDR_WIDTH-1:0]  jump_target;

  // Instruction memory (combinational read of imem_addr).
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  // IF/ID pipeline register contents.
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [ADDR_WIDTH-1:0]  if_id_pc_plus4;
  logic                   if_id_valid;

  modport master (
    output stall,
    output branch_taken,
    output branch_target,
    output jump_taken,
    output jump_target,
    output imem_rdata,
    input  imem_addr,
    input  if_id_instr,
    input  if_id_pc_plus4,
    input  if_id_valid
  );

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  jump_taken,
    input  jump_target,
    input  imem_rdata,
    output imem_addr,
    output if_id_instr,
    output if_id_pc_plus4,
    output if_id_valid
  );

endinterface

// File: rtl/if_fetch_stage_next_pc_sel.sv
// Next-PC priority mux. Branch beats jump (branch is the older instruction,
// resolved in EX), any redirect beats stall, and the sequential path is
// taken only when nothing else applies.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  stall,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  jumpTaken,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  input  logic [ADDR_WIDTH-1:0] pcCur,
  input  logic [ADDR_WIDTH-1:0] pcPlus4,
  output logic [ADDR_WIDTH-1:0] nextPc,
  output logic                  pcLoad,
  output logic                  ifIdLoad,
  output logic                  ifIdFlush
);

  pc_sel_e pcSel;

  // Pick the PC source by priority: branch, jump, stall, sequential.
  always_comb begin
    pcSel = PC_SEQ;
    if (branchTaken) begin
      pcSel = PC_BRANCH;
    end else if (jumpTaken) begin
      pcSel = PC_JUMP;
    end else if (stall) begin
      pcSel = PC_HOLD;
    end
  end

  // Steer the selected source onto nextPc and derive register enables.
  // Targets pass through unmodified; alignment is the producer's job.
  always_comb begin
    nextPc    = pcPlus4;
    pcLoad    = 1'b1;
    ifIdLoad  = 1'b0;
    ifIdFlush = 1'b0;
    case (pcSel)
      PC_BRANCH: begin
        nextPc    = branchTarget;
        ifIdFlush = 1'b1;
      end
      PC_JUMP: begin
        nextPc    = jumpTarget;
        ifIdFlush = 1'b1;
      end
      PC_HOLD: begin
        nextPc = pcCur;
        pcLoad = 1'b0;
      end
      default: begin
        nextPc   = pcPlus4;
        ifIdLoad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// The PC drives instruction memory directly; the fetched word and its PC+4
// are captured into IF/ID for decode and the jump-target shifter.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int                    INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = INSTR_WIDTH'(NOP_INSTR_DEFAULT)
) (
  input logic              clk,
  input logic              reset_n,
  if_fetch_stage_if.slave  bus
);

  logic [ADDR_WIDTH-1:0]  pcReg;
  logic [ADDR_WIDTH-1:0]  pcPlus4;
  logic [ADDR_WIDTH-1:0]  nextPc;
  logic                   pcLoad;
  logic                   ifIdLoad;
  logic                   ifIdFlush;

  logic [INSTR_WIDTH-1:0] ifIdInstrReg;
  logic [ADDR_WIDTH-1:0]  ifIdPcPlus4Reg;
  logic                   ifIdValidReg;

  // Sequential address; wraps silently at the top of the address space.
  assign pcPlus4 = pcReg + ADDR_WIDTH'(PC_STEP);

  next_pc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uNextPcSel (
    .stall        (bus.stall),
    .branchTaken  (bus.branch_taken),
    .branchTarget (bus.branch_target),
    .jumpTaken    (bus.jump_taken),
    .jumpTarget   (bus.jump_target),
    .pcCur        (pcReg),
    .pcPlus4      (pcPlus4),
    .nextPc       (nextPc),
    .pcLoad       (pcLoad),
    .ifIdLoad     (ifIdLoad),
    .ifIdFlush    (ifIdFlush)
  );

  // PC register: reload from the selected source unless stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcReg <= RESET_PC;
    end else if (pcLoad) begin
      pcReg <= nextPc;
    end
  end

  // IF/ID register: bubble on redirect, capture on sequential advance,
  // otherwise hold (stall keeps the current contents, no bubble).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifIdInstrReg   <= NOP_INSTR;
      ifIdPcPlus4Reg <= '0;
      ifIdValidReg   <= 1'b0;
    end else if (ifIdFlush) begin
      ifIdInstrReg   <= NOP_INSTR;
      ifIdPcPlus4Reg <= '0;
      ifIdValidReg   <= 1'b0;
    end else if (ifIdLoad) begin
      ifIdInstrReg   <= bus.imem_rdata;
      ifIdPcPlus4Reg <= pcPlus4;
      ifIdValidReg   <= 1'b1;
    end
  end

  // Every output is a flop output; no input reaches an output combinationally.
  assign bus.imem_addr      = pcReg;
  assign bus.if_id_instr    = ifIdInstrReg;
  assign bus.if_id_pc_plus4 = ifIdPcPlus4Reg;
  assign bus.if_id_valid    = ifIdValidReg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed walk through sequential fetch, stall,
// jump, branch/jump/stall collision, PC wrap and asynchronous reset, then a
// randomized run checked against a fetch-rule reference model.
module tb_if_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] IMEM_XOR = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n;

  if_fetch_stage_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) ifc ();

  if_fetch_stage #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000),
    .NOP_INSTR   (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A is A ^ IMEM_XOR.
  assign ifc.imem_rdata = ifc.imem_addr ^ IMEM_XOR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state: the architecturally visible fetch state.
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  logic        mValid;

  // Redirect targets must be word aligned; misalignment is a stimulus error.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!((ifc.branch_taken && ifc.branch_target[1:0] != 2'b00) ||
                (!ifc.branch_taken && ifc.jump_taken && ifc.jump_target[1:0] != 2'b00)))
      else begin
        bad++;
        $error("FAIL misaligned_target branch=%h jump=%h", ifc.branch_target, ifc.jump_target);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc    = 32'h0000_0000;
    mInstr = NOP;
    mPc4   = 32'h0000_0000;
    mValid = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".addr"},  ifc.imem_addr,         mPc);
    check({tag, ".instr"}, ifc.if_id_instr,       mInstr);
    check({tag, ".valid"}, {31'b0, ifc.if_id_valid}, {31'b0, mValid});
    if (mValid) check({tag, ".pc4"}, ifc.if_id_pc_plus4, mPc4);
  endtask

  // One clock of stimulus: drive inputs, advance the model by the fetch rules,
  // wait an edge, then compare on the falling edge.
  task automatic step(input string tag, input logic s, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    logic [31:0] nPc, nInstr, nPc4;
    logic        nValid;
    ifc.stall         = s;
    ifc.branch_taken  = br;
    ifc.branch_target = bt;
    ifc.jump_taken    = jp;
    ifc.jump_target   = jt;
    if (br || jp) begin
      nPc    = br ? bt : jt;
      nInstr = NOP;
      nPc4   = 32'h0;
      nValid = 1'b0;
    end else if (s) begin
      nPc    = mPc;
      nInstr = mInstr;
      nPc4   = mPc4;
      nValid = mValid;
    end else begin
      nPc    = mPc + 32'd4;
      nInstr = mPc ^ IMEM_XOR;
      nPc4   = mPc + 32'd4;
      nValid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    mPc = nPc; mInstr = nInstr; mPc4 = nPc4; mValid = nValid;
    cyc++;
    checkAll(tag);
    $display("cyc %0d %s s=%b br=%b jp=%b addr=%h instr=%h pc4=%h v=%b", cyc, tag, s, br, jp,
             ifc.imem_addr, ifc.if_id_instr, ifc.if_id_pc_plus4, ifc.if_id_valid);
  endtask

  initial begin
    reset_n           = 1'b0;
    ifc.stall         = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = 32'h0;
    ifc.jump_taken    = 1'b0;
    ifc.jump_target   = 32'h0;
    modelReset();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.addr",  ifc.imem_addr, 32'h0);
    check("rst.instr", ifc.if_id_instr, NOP);
    check("rst.pc4",   ifc.if_id_pc_plus4, 32'h0);
    check("rst.valid", {31'b0, ifc.if_id_valid}, 32'h0);
    reset_n = 1'b1;

    // Sequential fetch up to pc=8.
    step("seq0", 0, 0, 0, 0, 0);
    check("seq0.first_instr", ifc.if_id_instr, 32'hA5A5_0000);
    step("seq1", 0, 0, 0, 0, 0);
    check("seq1.pc4", ifc.if_id_pc_plus4, 32'h8);

    // Three stalled cycles at pc=8, then resume.
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0, 0);
    check("stall.addr_const", ifc.imem_addr, 32'h8);
    step("resume0", 0, 0, 0, 0, 0);
    check("resume0.addr", ifc.imem_addr, 32'hC);
    step("resume1", 0, 0, 0, 0, 0);

    // Jump from pc=0x10.
    step("jump", 0, 0, 0, 1, 32'h0040_0100);
    check("jump.addr", ifc.imem_addr, 32'h0040_0100);
    step("jump_after", 0, 0, 0, 0, 0);
    check("jump_after.pc4", ifc.if_id_pc_plus4, 32'h0040_0104);

    // Branch and jump together with stall: branch wins, stall ignored.
    step("collide", 1, 1, 32'h200, 1, 32'h300);
    check("collide.addr", ifc.imem_addr, 32'h200);
    step("collide_after", 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space.
    step("to_top", 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0, 0);
    check("wrap.pc4", ifc.if_id_pc_plus4, 32'h0);
    check("wrap.addr", ifc.imem_addr, 32'h0);
    step("wrap1", 0, 0, 0, 0, 0);
    step("wrap2", 0, 0, 0, 0, 0);

    // Asynchronous reset asserted between edges while a jump is pending.
    ifc.jump_taken  = 1'b1;
    ifc.jump_target = 32'h0000_0800;
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkAll("async_rst");
    check("async_rst.pc4", ifc.if_id_pc_plus4, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkAll("async_rst_hold");
    ifc.jump_taken = 1'b0;
    reset_n = 1'b1;

    // Randomized run.
    for (int i = 0; i < 200; i++) begin
      logic s, br, jp;
      logic [31:0] bt, jt;
      s  = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 10);
      jp = ($urandom_range(0, 99) < 10);
      bt = $urandom() & 32'hFFFF_FFFC;
      jt = $urandom() & 32'hFFFF_FFFC;
      step("rand", s, br, bt, jp, jt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
